melody_sequencer: RTL and testbench

//  Upstream control stage for the SPI DAC tone master. Debounces Play/Stop buttons, steps a

---
 rtl/melody_pkg.sv | 60 ++++++
 rtl/btn_debounce.sv | 56 +++++
 rtl/melody_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_melody_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Purpose: shared types, note codes and the fixed melody table for the tone sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package melody_pkg;

    localparam int MELODY_LEN = 16;

    // Note codes understood by the SPI DAC tone master; 0 is silence.
    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_A1   = 4'd1,
        NOTE_A2   = 4'd2,
        NOTE_B1   = 4'd3,
        NOTE_C1   = 4'd4,
        NOTE_D1   = 4'd5,
        NOTE_E2   = 4'd6,
        NOTE_G1   = 4'd7,
        NOTE_G2   = 4'd8,
        NOTE_F1   = 4'd9,
        NOTE_F2H  = 4'd10
    } note_e;

    typedef struct packed {
        note_e       note;
        logic [11:0] dur_ms;
    } seq_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_e;

    // Bring-up melody; a zero duration marks the end of the tune.
    localparam seq_entry_t MELODY [MELODY_LEN] = '{
        '{NOTE_A1,   12'd3},
        '{NOTE_REST, 12'd2},
        '{NOTE_G2,   12'd1},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0},
        '{NOTE_REST, 12'd0}
    };

    function automatic logic is_end_marker(input seq_entry_t e);
        return (e.dur_ms == 12'd0);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-FF synchroniser + tick-based stable-level filter + rising-edge pulse for one button.
// Latency: 2 cycles sync, then DEBOUNCE_MS consecutive ticks at the new level, then 1-cycle btn_ev.
// Backpressure: none; btn_ev is a single-cycle pulse, the consumer must take it when it fires.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic tick,
    output logic btn_ev
);

    localparam int DEB_W = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic             deb_q;
    logic             deb_d;
    logic [DEB_W-1:0] stable_cnt;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after it has been seen on DEBOUNCE_MS ticks in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q      <= 1'b0;
            deb_d      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            deb_d <= deb_q;
            if (sync_q2 == deb_q) begin
                stable_cnt <= '0;
            end else if (tick) begin
                if (stable_cnt == DEB_W'(DEBOUNCE_MS - 1)) begin
                    deb_q      <= sync_q2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
        end
    end

    assign btn_ev = deb_q & ~deb_d;

endmodule

// File: rtl/melody_sequencer.sv
// Purpose: debounces Play/Stop and steps the melody table, driving note_state/button_action to the tone master.
// Latency: play_ev in cycle N -> LOAD at N+1 -> button_action at N+2; stop_ev clears outputs next cycle.
// Backpressure: none; the downstream master follows note_state/button_action level by level.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int SEQ_LEN     = MELODY_LEN,
    parameter int DEBOUNCE_MS = 20,
    parameter int GAP_MS      = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_play,
    input  logic                       btn_stop,
    input  logic                       loop_en,
    output logic [3:0]                 note_state,
    output logic                       button_action,
    output logic [$clog2(SEQ_LEN)-1:0] seq_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int ADDR_W = $clog2(SEQ_LEN);
    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W  = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;

    state_e            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              play_ev;
    logic              stop_ev;
    logic [11:0]       dur_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              wrapped;
    logic              last_idx;
    logic              at_end;
    logic              restart_ok;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] rd_addr;
    seq_entry_t        rom_q;

    assign tick = (tick_cnt == TICK_W'(DIV - 1));

    // Free-running tick divider, realigned in LOAD so every note/gap is a whole number of ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (state == ST_LOAD || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_play_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_play),
        .tick    (tick),
        .btn_ev  (play_ev)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_stop_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_stop),
        .tick    (tick),
        .btn_ev  (stop_ev)
    );

    assign last_idx   = (seq_idx == ADDR_W'(SEQ_LEN - 1));
    assign idx_inc    = last_idx ? '0 : seq_idx + 1'b1;
    assign at_end     = is_end_marker(rom_q) || wrapped;
    assign restart_ok = wrapped || (seq_idx != '0);

    // Address the ROM with the index that seq_idx will hold next, so LOAD sees its own entry.
    always_comb begin
        rd_addr = seq_idx;
        case (state)
            ST_IDLE: rd_addr = '0;
            ST_LOAD: if (at_end && loop_en && restart_ok) rd_addr = '0;
            ST_PLAY: if (GAP_MS == 0 && tick && dur_cnt == 12'd1) rd_addr = idx_inc;
            ST_GAP:  if (tick && gap_cnt == GAP_W'(1)) rd_addr = idx_inc;
            default: rd_addr = seq_idx;
        endcase
    end

    // Registered melody ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_q <= '0;
        end else begin
            rom_q <= MELODY[rd_addr];
        end
    end

    // Sequencer FSM with registered outputs; stop aborts any active state without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            note_state    <= '0;
            button_action <= 1'b0;
            seq_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            dur_cnt       <= '0;
            gap_cnt       <= '0;
            wrapped       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop_ev && (state == ST_LOAD || state == ST_PLAY || state == ST_GAP)) begin
                state         <= ST_IDLE;
                note_state    <= '0;
                button_action <= 1'b0;
                seq_idx       <= '0;
                busy          <= 1'b0;
                wrapped       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        note_state    <= '0;
                        button_action <= 1'b0;
                        seq_idx       <= '0;
                        busy          <= 1'b0;
                        wrapped       <= 1'b0;
                        if (play_ev && !stop_ev) begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (at_end) begin
                            if (loop_en && restart_ok) begin
                                seq_idx <= rd_addr;
                                wrapped <= 1'b0;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            note_state    <= rom_q.note;
                            button_action <= (rom_q.note != NOTE_REST);
                            dur_cnt       <= rom_q.dur_ms;
                            state         <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            if (dur_cnt == 12'd1) begin
                                note_state    <= '0;
                                button_action <= 1'b0;
                                if (GAP_MS == 0) begin
                                    seq_idx <= rd_addr;
                                    wrapped <= last_idx;
                                    state   <= ST_LOAD;
                                end else begin
                                    gap_cnt <= GAP_W'(GAP_MS);
                                    state   <= ST_GAP;
                                end
                            end else begin
                                dur_cnt <= dur_cnt - 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (tick) begin
                            if (gap_cnt == GAP_W'(1)) begin
                                seq_idx <= rd_addr;
                                wrapped <= last_idx;
                                state   <= ST_LOAD;
                            end else begin
                                gap_cnt <= gap_cnt - 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy    <= 1'b0;
                        seq_idx <= '0;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Purpose: self-checking bench for melody_sequencer using a phase table expanded into a per-cycle scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_melody_sequencer;

    localparam int CPT     = 10;      // clock cycles per tick with the parameters below
    localparam int GAP_CYC = 1 * CPT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_play;
    logic       btn_stop;
    logic       loop_en;
    logic [3:0] note_state;
    logic       button_action;
    logic [3:0] seq_idx;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    melody_sequencer #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .SEQ_LEN     (16),
        .DEBOUNCE_MS (2),
        .GAP_MS      (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_play      (btn_play),
        .btn_stop      (btn_stop),
        .loop_en       (loop_en),
        .note_state    (note_state),
        .button_action (button_action),
        .seq_idx       (seq_idx),
        .busy          (busy),
        .done          (done)
    );

    // One record per output phase: how many cycles it lasts and what the outputs must be.
    typedef struct {
        int         run;
        logic       lp;
        int         cycles;
        logic       ba;
        logic [3:0] note;
        logic [3:0] idx;
        logic       bz;
        logic       dn;
    } row_t;

    typedef struct {
        int         row;
        logic       ba;
        logic [3:0] note;
        logic [3:0] idx;
        logic       bz;
        logic       dn;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic add_row(input int run, input logic lp, input int cyc, input logic ba,
                           input logic [3:0] note, input logic [3:0] idx, input logic bz, input logic dn);
        row_t r;
        r.run = run; r.lp = lp; r.cycles = cyc; r.ba = ba;
        r.note = note; r.idx = idx; r.bz = bz; r.dn = dn;
        rows.push_back(r);
    endtask

    // Table {A1,3},{REST,2},{G2,1},{end}: LOAD, note, gap for each entry, then the final LOAD.
    task automatic add_melody(input int run, input logic lp);
        add_row(run, lp, 1,       1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        add_row(run, lp, 3 * CPT, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0);
        add_row(run, lp, GAP_CYC, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        add_row(run, lp, 1,       1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
        add_row(run, lp, 2 * CPT, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
        add_row(run, lp, GAP_CYC, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0);
        add_row(run, lp, 1,       1'b0, 4'd0, 4'd2, 1'b1, 1'b0);
        add_row(run, lp, 1 * CPT, 1'b1, 4'd8, 4'd2, 1'b1, 1'b0);
        add_row(run, lp, GAP_CYC, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0);
        add_row(run, lp, 1,       1'b0, 4'd0, 4'd3, 1'b1, 1'b0);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, {31'd0, lvl});
    endtask

    // Start a run, then compare every cycle against the scoreboard; Play is re-pressed mid-melody.
    task automatic run_melody(input int run, input logic lp);
        int   c;
        exp_t e;
        loop_en  = lp;
        btn_play = 1'b1;
        wait_busy(1'b1, 40, $sformatf("run%0d_start", run));
        if (busy === 1'b1) begin
            foreach (rows[i]) begin
                if (rows[i].run == run) begin
                    for (int k = 0; k < rows[i].cycles; k++) begin
                        e.row = i; e.ba = rows[i].ba; e.note = rows[i].note;
                        e.idx = rows[i].idx; e.bz = rows[i].bz; e.dn = rows[i].dn;
                        sb.push_back(e);
                    end
                end
            end
            c = 0;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (c == 0)  btn_play = 1'b0;
                if (c == 35) btn_play = 1'b1;
                if (c == 60) btn_play = 1'b0;
                check($sformatf("run%0d_row%0d_cyc%0d", run, e.row, c),
                      {21'd0, button_action, note_state, seq_idx, busy, done},
                      {21'd0, e.ba, e.note, e.idx, e.bz, e.dn});
                @(negedge clk);
                c++;
            end
        end
        btn_play = 1'b0;
    endtask

    initial begin
        logic seen;
        logic prev_ba;
        int   n;

        rst_n = 1'b0; btn_play = 1'b0; btn_stop = 1'b0; loop_en = 1'b0;

        add_melody(0, 1'b0);
        add_row(0, 1'b0, 1, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1);   // DONE pulse
        add_row(0, 1'b0, 5, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);   // back in IDLE
        add_melody(1, 1'b1);
        add_row(1, 1'b1, 1,       1'b0, 4'd0, 4'd0, 1'b1, 1'b0);  // restart LOAD at 0
        add_row(1, 1'b1, 3 * CPT, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0);  // A1 again

        repeat (3) @(negedge clk);
        check("reset_state", {21'd0, button_action, note_state, seq_idx, busy, done}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {21'd0, button_action, note_state, seq_idx, busy, done}, 32'd0);

        // Full melody without loop, then with loop.
        run_melody(0, 1'b0);
        repeat (40) @(negedge clk);
        run_melody(1, 1'b1);
        btn_stop = 1'b1;
        wait_busy(1'b0, 40, "loop_stop_busy");
        check("loop_stop_outputs", {23'd0, button_action, note_state, seq_idx, done}, 32'd0);
        btn_stop = 1'b0;
        loop_en  = 1'b0;
        repeat (40) @(negedge clk);

        // Bouncing Play must not start; a steady press must.
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            btn_play = (i % 2 == 0);
            repeat (5) begin
                @(negedge clk);
                if (busy === 1'b1) seen = 1'b1;
            end
        end
        check("bounce_ignored", {31'd0, seen}, 32'd0);
        btn_play = 1'b1;
        wait_busy(1'b1, 30, "held_start");

        // Stop during the first note.
        repeat (2) @(negedge clk);
        check("first_note_on", {27'd0, button_action, note_state}, {27'd0, 1'b1, 4'd1});
        btn_play = 1'b0;
        btn_stop = 1'b1;
        prev_ba  = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            prev_ba = button_action;
            @(negedge clk);
            n++;
        end
        check("stop_busy_low", {31'd0, busy}, 32'd0);
        check("stop_ba_before", {31'd0, prev_ba}, 32'd1);
        check("stop_outputs", {22'd0, button_action, note_state, seq_idx, done}, 32'd0);
        btn_stop = 1'b0;
        repeat (40) @(negedge clk);

        // Play and Stop together from IDLE: stop wins.
        btn_play = 1'b1;
        btn_stop = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        check("play_stop_same_cycle", {31'd0, seen}, 32'd0);
        btn_play = 1'b0;
        btn_stop = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of a note.
        btn_play = 1'b1;
        wait_busy(1'b1, 40, "rst_start");
        btn_play = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_pre_ba", {31'd0, button_action}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", {21'd0, button_action, note_state, seq_idx, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_idle", {21'd0, button_action, note_state, seq_idx, busy, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
